// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and default sizes for the buffered serial receiver
package rx_pkg;

  localparam int DEF_PKT_W = 55;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/rx_deserializer.sv
// rtl/rx_deserializer.sv - framed serial deserialiser; optional even parity via RX_PARITY_EN
module rx_deserializer
  import rx_pkg::*;
#(
  parameter int PKT_W = DEF_PKT_W
) (
  input  logic             Clk_S,
  input  logic             Rst_n,
  input  logic             S_Data,
  output logic [PKT_W-1:0] pkt,
  output logic             pkt_push,
  output logic             frame_err
);

  localparam int BC_W = (PKT_W > 1) ? $clog2(PKT_W) : 1;

  rx_state_t       state, state_nxt;
  logic [BC_W-1:0] bitcnt;
  logic [PKT_W-1:0] shreg;
  logic            last_bit;
  logic            par_ok;

  assign last_bit = (bitcnt == BC_W'(PKT_W - 1));
  assign pkt      = shreg;

`ifdef RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      par_bit <= 1'b0;
    end else if (state == PARITY) begin
      par_bit <= S_Data;
    end
  end

  assign par_ok = ~(^shreg ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!S_Data) state_nxt = DATA;
      DATA: begin
        if (last_bit) begin
`ifdef RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // shreg is held through STOP and the following cycle, so the FIFO can
  // write it directly on the registered push
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      pkt_push  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pkt_push  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: bitcnt <= '0;
        DATA: begin
          shreg[bitcnt] <= S_Data;
          bitcnt        <= bitcnt + BC_W'(1);
        end
        STOP: begin
          pkt_push  <= S_Data & par_ok;
          frame_err <= ~(S_Data & par_ok);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_buffered_receiver.sv
// rtl/rx_buffered_receiver.sv - serial receiver with DEPTH-packet FIFO and valid/ready output; RX_PARITY_EN enables parity
module rx_buffered_receiver
  import rx_pkg::*;
#(
  parameter  int PKT_W = DEF_PKT_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             Clk_S,
  input  logic             Rst_n,
  input  logic             S_Data,
  input  logic             RX_Ready,
  output logic             RX_Data_Valid,
  output logic [PKT_W-1:0] RX_Data,
  output logic [CNT_W-1:0] RX_Count,
  output logic             RX_Frame_Err,
  output logic             RX_Overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PKT_W-1:0] pkt;
  logic             pkt_push;
  logic             frame_err;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, push;

  rx_deserializer #(.PKT_W(PKT_W)) u_deser (
    .Clk_S     (Clk_S),
    .Rst_n     (Rst_n),
    .S_Data    (S_Data),
    .pkt       (pkt),
    .pkt_push  (pkt_push),
    .frame_err (frame_err)
  );

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = RX_Data_Valid & RX_Ready;
  // a pop in the same cycle frees the slot the incoming packet needs
  assign push = pkt_push & (~full | pop);

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      RX_Overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pkt;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      RX_Overflow <= pkt_push & full & ~pop;
    end
  end

  assign RX_Data_Valid = (count != '0);
  assign RX_Data       = mem[rd_ptr];
  assign RX_Count      = count;
  assign RX_Frame_Err  = frame_err;

endmodule

// File: tb/tb_rx_buffered_receiver.sv
// tb/tb_rx_buffered_receiver.sv - randomized self-checking bench with a queue-based reference model
module tb_rx_buffered_receiver;

  localparam int PKT_W = 55;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             Clk_S = 1'b0;
  logic             Rst_n;
  logic             S_Data;
  logic             RX_Ready;
  logic             RX_Data_Valid;
  logic [PKT_W-1:0] RX_Data;
  logic [CNT_W-1:0] RX_Count;
  logic             RX_Frame_Err;
  logic             RX_Overflow;

  rx_buffered_receiver #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .Clk_S         (Clk_S),
    .Rst_n         (Rst_n),
    .S_Data        (S_Data),
    .RX_Ready      (RX_Ready),
    .RX_Data_Valid (RX_Data_Valid),
    .RX_Data       (RX_Data),
    .RX_Count      (RX_Count),
    .RX_Frame_Err  (RX_Frame_Err),
    .RX_Overflow   (RX_Overflow)
  );

  always #5 Clk_S = ~Clk_S;

  int n_cmp = 0;
  int n_err = 0;

  logic [PKT_W-1:0] mq[$];
  logic             pend_push = 1'b0;
  logic [PKT_W-1:0] pend_pkt  = '0;
  logic [PKT_W-1:0] cur_pkt   = '0;
  logic             e_ferr    = 1'b0;
  logic             e_ovf     = 1'b0;
  int               rdy_mode  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // kind: 0 = ordinary bit, 1 = good stop bit, 2 = stop bit of a rejected frame
  task automatic tick(input logic s, input logic r, input int kind);
    logic pop;
    S_Data   = s;
    RX_Ready = r;
    @(posedge Clk_S);
    pop   = (mq.size() > 0) && r;
    e_ovf = 1'b0;
    if (pop) void'(mq.pop_front());
    if (pend_push) begin
      if (mq.size() < DEPTH) mq.push_back(pend_pkt);
      else e_ovf = 1'b1;
    end
    pend_push = (kind == 1);
    pend_pkt  = cur_pkt;
    e_ferr    = (kind == 2);
    #1;
    check_eq("valid", 64'(RX_Data_Valid), 64'(mq.size() > 0));
    check_eq("count", 64'(RX_Count), 64'(mq.size()));
    if (mq.size() > 0) check_eq("data", 64'(RX_Data), 64'(mq[0]));
    check_eq("frame_err", 64'(RX_Frame_Err), 64'(e_ferr));
    check_eq("overflow", 64'(RX_Overflow), 64'(e_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, pick_rdy(), 0);
  endtask

  task automatic send_frame(input logic [PKT_W-1:0] p, input bit bad_stop, input bit bad_par);
    bit bad;
    cur_pkt = p;
    tick(1'b0, pick_rdy(), 0);
    for (int i = 0; i < PKT_W; i++) tick(p[i], pick_rdy(), 0);
`ifdef RX_PARITY_EN
    tick((^p) ^ bad_par, pick_rdy(), 0);
    bad = bad_stop | bad_par;
`else
    bad = bad_stop;
`endif
    tick(~bad_stop, pick_rdy(), bad ? 2 : 1);
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[PKT_W-1:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(RX_Data_Valid), 64'd0);
    check_eq({tag, "_count"}, 64'(RX_Count), 64'd0);
    check_eq({tag, "_data"}, 64'(RX_Data), 64'd0);
    check_eq({tag, "_ferr"}, 64'(RX_Frame_Err), 64'd0);
    check_eq({tag, "_ovf"}, 64'(RX_Overflow), 64'd0);
  endtask

  initial begin
    logic [59:0] lit;
    Rst_n    = 1'b0;
    S_Data   = 1'b1;
    RX_Ready = 1'b0;
    repeat (3) @(posedge Clk_S);
    #1;
    check_all_zero("reset");
    Rst_n = 1'b1;
    idle(2);

    // single frame, consumer always ready
    rdy_mode = 1;
    lit = 60'h0A5A5A5A5A5A5A5;
    send_frame(lit[PKT_W-1:0], 0, 0);
    idle(3);

    // six back-to-back frames into a stalled consumer, then drain
    rdy_mode = 0;
    for (int k = 0; k < 6; k++) send_frame(rnd_pkt(), 0, 0);
    idle(2);
    rdy_mode = 1;
    idle(6);

    // bad stop bit, then a good frame
    rdy_mode = 2;
    send_frame(rnd_pkt(), 1, 0);
    send_frame(rnd_pkt(), 0, 0);
    rdy_mode = 1;
    idle(4);

    // full FIFO, pop coincides with the fifth push
    rdy_mode = 0;
    for (int k = 0; k < 5; k++) send_frame(rnd_pkt(), 0, 0);
    tick(1'b1, 1'b1, 0);
    rdy_mode = 1;
    idle(6);

    // async reset in the middle of a data phase with two packets buffered
    rdy_mode = 0;
    send_frame(rnd_pkt(), 0, 0);
    send_frame(rnd_pkt(), 0, 0);
    idle(2);
    check_eq("pre_reset_count", 64'(RX_Count), 64'd2);
    tick(1'b0, 1'b0, 0);
    for (int i = 0; i < 7; i++) tick(1'($urandom_range(0, 1)), 1'b0, 0);
    #2;
    Rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    mq.delete();
    pend_push = 1'b0;
    S_Data = 1'b1;
    @(posedge Clk_S);
    #3;
    Rst_n = 1'b1;
    rdy_mode = 2;
    idle(2);
    send_frame(rnd_pkt(), 0, 0);
    rdy_mode = 1;
    idle(3);

`ifdef RX_PARITY_EN
    rdy_mode = 2;
    send_frame(rnd_pkt(), 0, 1);
    send_frame(rnd_pkt(), 0, 0);
    rdy_mode = 1;
    idle(4);
`endif

    // randomized traffic with gaps, stalls and occasional bad frames
    rdy_mode = 2;
    for (int k = 0; k < 25; k++) begin
      send_frame(rnd_pkt(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      idle($urandom_range(0, 2));
    end
    rdy_mode = 1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
